// File: rtl/conv_l1_pkg.sv
// Shared types and geometry for the layer-1 convolution engine.
// Counter widths are derived from the kernel size and the output-map size.
package conv_l1_pkg;

   localparam int IMG_W  = 32;
   localparam int IMG_H  = 32;
   localparam int K      = 5;
   localparam int OUT_W  = IMG_W - K + 1;
   localparam int OUT_H  = IMG_H - K + 1;
   localparam int ADDR_W = 10;

   localparam int KW  = $clog2(K);
   localparam int OXW = $clog2(OUT_W);
   localparam int OYW = $clog2(OUT_H);

   typedef logic [ADDR_W-1:0] addr_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/cnt_down.sv
// Down-counter that reloads LD_VAL after reaching zero.
// The terminal count (cnt == 0) is decoded by the user of the counter.
module cnt_down #(
   parameter int          W      = 4,
   parameter logic [W-1:0] LD_VAL = '0
) (
   input  logic         cnt_clk,
   input  logic         cnt_rstn,
   input  logic         clr,
   input  logic         cnt_en,
   output logic [W-1:0] cnt
);

   always_ff @(posedge cnt_clk or negedge cnt_rstn) begin
      if (!cnt_rstn) begin
         cnt <= LD_VAL;
      end else if (clr) begin
         cnt <= LD_VAL;
      end else if (cnt_en) begin
         if (cnt == '0) cnt <= LD_VAL;
         else           cnt <= cnt - W'(1);
      end
   end

endmodule

// File: rtl/conv_win_addr_gen.sv
// Sliding-window read-address generator: walks every KxK window in raster
// order, one linear SRAM address per tap, built incrementally from two bases.
//
// state | meaning
// IDLE  | waiting for start, rd_valid low
// RUN   | presenting taps, advancing on rd_valid & rd_ready
// DONE  | one-cycle done pulse after the final tap was accepted
module conv_win_addr_gen
   import conv_l1_pkg::*;
(
   input  logic              cnt_clk,
   input  logic              cnt_rstn,
   input  logic              start,
   input  logic              abort,
   input  logic              rd_ready,
   output logic              rd_valid,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              win_first,
   output logic              win_last,
   output logic              busy,
   output logic              done
);

   localparam addr_t STEP_COL  = addr_t'(1);
   localparam addr_t STEP_ROW  = addr_t'(IMG_W);
   localparam addr_t STEP_WRAP = addr_t'(K);

   localparam logic [KW-1:0]  KX_LD  = KW'(K - 1);
   localparam logic [KW-1:0]  KX_ONE = KW'(1);
   localparam logic [OXW-1:0] OX_LD  = OXW'(OUT_W - 1);
   localparam logic [OYW-1:0] OY_LD  = OYW'(OUT_H - 1);

   state_t         state;
   addr_t          win_base;
   addr_t          row_base;
   addr_t          next_win;
   logic [KW-1:0]  kx_cnt;
   logic [KW-1:0]  ky_cnt;
   logic [OXW-1:0] ox_cnt;
   logic [OYW-1:0] oy_cnt;
   logic           accept;
   logic           kx_wrap, ky_wrap, ox_wrap, oy_wrap;
   logic           ky_en, ox_en, oy_en;
   logic           last_tap;
   logic           cnt_clr;

   assign accept   = (state == RUN) & rd_valid & rd_ready;
   assign kx_wrap  = (kx_cnt == '0);
   assign ky_wrap  = (ky_cnt == '0);
   assign ox_wrap  = (ox_cnt == '0);
   assign oy_wrap  = (oy_cnt == '0);
   assign ky_en    = accept & kx_wrap;
   assign ox_en    = ky_en & ky_wrap;
   assign oy_en    = ox_en & ox_wrap;
   assign last_tap = kx_wrap & ky_wrap & ox_wrap & oy_wrap;
   assign cnt_clr  = abort | (state == DONE);

   // Last window of a row steps +K to land on the first window of the next row.
   assign next_win = win_base + (ox_wrap ? STEP_WRAP : STEP_COL);

   cnt_down #(.W(KW),  .LD_VAL(KX_LD)) u_kx (
      .cnt_clk(cnt_clk), .cnt_rstn(cnt_rstn), .clr(cnt_clr), .cnt_en(accept), .cnt(kx_cnt));
   cnt_down #(.W(KW),  .LD_VAL(KX_LD)) u_ky (
      .cnt_clk(cnt_clk), .cnt_rstn(cnt_rstn), .clr(cnt_clr), .cnt_en(ky_en),  .cnt(ky_cnt));
   cnt_down #(.W(OXW), .LD_VAL(OX_LD)) u_ox (
      .cnt_clk(cnt_clk), .cnt_rstn(cnt_rstn), .clr(cnt_clr), .cnt_en(ox_en),  .cnt(ox_cnt));
   cnt_down #(.W(OYW), .LD_VAL(OY_LD)) u_oy (
      .cnt_clk(cnt_clk), .cnt_rstn(cnt_rstn), .clr(cnt_clr), .cnt_en(oy_en),  .cnt(oy_cnt));

   always_ff @(posedge cnt_clk or negedge cnt_rstn) begin
      if (!cnt_rstn) begin
         state     <= IDLE;
         rd_valid  <= 1'b0;
         rd_addr   <= '0;
         win_first <= 1'b0;
         win_last  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         win_base  <= '0;
         row_base  <= '0;
      end else if (abort) begin
         state     <= IDLE;
         rd_valid  <= 1'b0;
         rd_addr   <= '0;
         win_first <= 1'b0;
         win_last  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         win_base  <= '0;
         row_base  <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state     <= RUN;
                  rd_valid  <= 1'b1;
                  rd_addr   <= '0;
                  win_first <= 1'b1;
                  win_last  <= 1'b0;
                  busy      <= 1'b1;
                  win_base  <= '0;
                  row_base  <= '0;
               end
            end
            RUN: begin
               if (accept) begin
                  if (last_tap) begin
                     state     <= DONE;
                     rd_valid  <= 1'b0;
                     rd_addr   <= '0;
                     win_first <= 1'b0;
                     win_last  <= 1'b0;
                     done      <= 1'b1;
                     win_base  <= '0;
                     row_base  <= '0;
                  end else if (!kx_wrap) begin
                     rd_addr   <= rd_addr + STEP_COL;
                     win_first <= 1'b0;
                     win_last  <= ky_wrap & (kx_cnt == KX_ONE);
                  end else if (!ky_wrap) begin
                     row_base  <= row_base + STEP_ROW;
                     rd_addr   <= row_base + STEP_ROW;
                     win_first <= 1'b0;
                     win_last  <= 1'b0;
                  end else begin
                     win_base  <= next_win;
                     row_base  <= next_win;
                     rd_addr   <= next_win;
                     win_first <= 1'b1;
                     win_last  <= 1'b0;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
            default: begin
               state    <= IDLE;
               rd_valid <= 1'b0;
               busy     <= 1'b0;
               done     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_conv_win_addr_gen.sv
// Directed bench for conv_win_addr_gen: first-window vector table plus
// full scans against an index-arithmetic reference, abort and reset cases.
`timescale 1ns/1ps
module tb_conv_win_addr_gen;

   localparam int IMG_W = 32;
   localparam int K     = 5;
   localparam int OUT_W = 28;
   localparam int TOTAL = 19600;

   logic       cnt_clk = 1'b0;
   logic       cnt_rstn;
   logic       start, abort, rd_ready;
   logic       rd_valid, win_first, win_last, busy, done;
   logic [9:0] rd_addr;

   int n_checks = 0;
   int n_err    = 0;

   typedef struct {
      logic ready;
      int   addr;
      logic first;
      logic last;
   } vec_t;
   vec_t vq[$];

   conv_win_addr_gen dut (
      .cnt_clk(cnt_clk), .cnt_rstn(cnt_rstn), .start(start), .abort(abort),
      .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_addr(rd_addr),
      .win_first(win_first), .win_last(win_last), .busy(busy), .done(done));

   always #5 cnt_clk = ~cnt_clk;

   task automatic tick();
      @(negedge cnt_clk);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         if (n_err <= 20) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // {valid, busy, done, first, last, addr}
   function automatic logic [31:0] obs();
      return {17'd0, rd_valid, busy, done, win_first, win_last, rd_addr};
   endfunction

   function automatic logic [31:0] pack(input logic v, input logic b, input logic d,
                                        input logic f, input logic l, input int a);
      logic [9:0] a10;
      a10 = a[9:0];
      return {17'd0, v, b, d, f, l, a10};
   endfunction

   function automatic logic [31:0] model(input int acc);
      int kx, ky, w, ox, oy;
      kx = acc % K;
      ky = (acc / K) % K;
      w  = acc / (K * K);
      ox = w % OUT_W;
      oy = w / OUT_W;
      return pack(1'b1, 1'b1, 1'b0, (kx == 0 && ky == 0), (kx == K-1 && ky == K-1),
                  (oy + ky) * IMG_W + ox + kx);
   endfunction

   task automatic add(input logic r, input int a, input logic f, input logic l);
      vec_t v;
      v.ready = r; v.addr = a; v.first = f; v.last = l;
      vq.push_back(v);
   endtask

   task automatic scan(input bit rnd, input int abort_at, input int restart_at);
      int          acc = 0;
      int          cyc = 0;
      bit          stalled = 0;
      bit          rdy, ab;
      logic [31:0] prev = '0;
      start = 1'b1; tick(); start = 1'b0;
      while (acc < TOTAL) begin
         cyc++;
         if (cyc > 60000) begin
            check("scan_timeout_accepts", acc, TOTAL);
            return;
         end
         check("tap", obs(), model(acc));
         if (stalled) check("hold_stall", obs(), prev);
         if (!rnd) begin
            if (acc == 25)  check("win1_first", {win_first, rd_addr}, {1'b1, 10'd1});
            if (acc == 675) check("win_ox27",   {win_first, rd_addr}, {1'b1, 10'd27});
            if (acc == 700) check("row_wrap",   {win_first, rd_addr}, {1'b1, 10'd32});
         end
         if (acc == TOTAL-1) check("final_tap", {win_last, rd_addr}, {1'b1, 10'd1023});
         rdy      = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
         ab       = (acc == abort_at);
         rd_ready = rdy;
         abort    = ab;
         start    = (acc == restart_at);
         prev     = obs();
         stalled  = !rdy;
         tick();
         abort = 1'b0; start = 1'b0;
         if (ab) begin
            check("abort_idle", {rd_valid, busy, done}, 3'b000);
            repeat (3) begin
               tick();
               check("abort_no_done", {rd_valid, busy, done}, 3'b000);
            end
            return;
         end
         if (rdy) acc++;
      end
      check("done_pulse", {rd_valid, busy, done}, 3'b011);
      tick();
      check("after_done", {rd_valid, busy, done}, 3'b000);
   endtask

   initial begin
      cnt_rstn = 1'b0; start = 1'b0; abort = 1'b0; rd_ready = 1'b0;
      repeat (2) tick();
      check("reset_outputs", obs(), 32'd0);
      cnt_rstn = 1'b1;
      tick();
      check("idle_after_reset", obs(), 32'd0);

      // First window with a few stalls, then the first tap of window 2.
      add(1,0,1,0);   add(1,1,0,0);   add(1,2,0,0);   add(0,3,0,0);   add(1,3,0,0);   add(1,4,0,0);
      add(1,32,0,0);  add(1,33,0,0);  add(1,34,0,0);  add(1,35,0,0);  add(1,36,0,0);
      add(1,64,0,0);  add(1,65,0,0);  add(1,66,0,0);  add(1,67,0,0);  add(1,68,0,0);
      add(1,96,0,0);  add(1,97,0,0);  add(1,98,0,0);  add(1,99,0,0);  add(1,100,0,0);
      add(1,128,0,0); add(1,129,0,0); add(1,130,0,0); add(1,131,0,0);
      add(0,132,0,1); add(1,132,0,1); add(0,1,1,0);

      start = 1'b1; tick(); start = 1'b0;
      foreach (vq[i]) begin
         check("win0_tap", obs(), pack(1'b1, 1'b1, 1'b0, vq[i].first, vq[i].last, vq[i].addr));
         rd_ready = vq[i].ready;
         tick();
      end
      abort = 1'b1; tick(); abort = 1'b0;
      check("abort_after_table", {rd_valid, busy, done}, 3'b000);

      // abort beats start in IDLE
      start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
      check("abort_start_idle", {rd_valid, busy}, 2'b00);
      tick();
      check("abort_start_idle2", {rd_valid, busy}, 2'b00);

      scan(1'b0, -1, 1000);   // full scan, start re-asserted mid-scan
      scan(1'b1, -1, -1);     // back-to-back, random backpressure
      scan(1'b0, 500, -1);    // abort at tap 500

      rd_ready = 1'b1;
      start = 1'b1; tick(); start = 1'b0;
      check("restart_after_abort", obs(), model(0));
      repeat (12) tick();
      check("mid_window_tap", obs(), model(12));
      #2 cnt_rstn = 1'b0;
      #1 check("async_reset_outputs", obs(), 32'd0);
      tick();
      cnt_rstn = 1'b1;
      tick();
      check("idle_after_mid_reset", obs(), 32'd0);
      start = 1'b1; tick(); start = 1'b0;
      check("restart_after_reset", obs(), model(0));
      tick();
      check("restart_second_tap", obs(), model(1));

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
